// File: rtl/calc_pkg.sv
// Shared command/response codes and the per-port sequencer state encoding
// for the calc request sequencer.
package calc_pkg;

   localparam int CMD_NOP = 0;
   localparam int CMD_ADD = 1;
   localparam int CMD_SUB = 2;
   localparam int CMD_LSH = 5;
   localparam int CMD_RSH = 6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP1  = 2'd1,
      OP2  = 2'd2,
      WAIT = 2'd3
   } seq_state_e;

   // Any non-zero code, including the reserved one, counts as a DUV response.
   function automatic logic resp_present(input logic [1:0] resp);
      return resp != RESP_NONE;
   endfunction

endpackage

// File: rtl/calc_port_seq.sv
// One independent request channel: transaction FIFO, two-cycle request FSM
// with response wait and timeout, and the completion record registers.
module calc_port_seq
   import calc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CMD_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   // Push handshake: an entry is taken at a rising edge where txn_valid_i and
   // txn_ready_o are both high; ready depends only on registered state.
   input  logic              txn_valid_i,
   output logic              txn_ready_o,
   input  logic [CMD_W-1:0]  txn_cmd_i,
   input  logic [DATA_W-1:0] txn_op1_i,
   input  logic [DATA_W-1:0] txn_op2_i,
   output logic [CMD_W-1:0]  req_cmd_o,
   output logic [DATA_W-1:0] req_data_o,
   input  logic [1:0]        out_resp_i,
   input  logic [DATA_W-1:0] out_data_i,
   output logic              cpl_valid_o,
   output logic [1:0]        cpl_resp_o,
   output logic [DATA_W-1:0] cpl_data_o,
   output logic              cpl_timeout_o,
   output logic              busy_o,
   output logic              err_spurious_o,
   output logic [1:0]        state_o
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PW    = AW + 1;
   localparam int ENT_W = CMD_W + 2 * DATA_W;
   localparam int CW    = $clog2(TIMEOUT) + 1;

   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              full, empty, push, pop;
   logic [ENT_W-1:0]  head;
   logic [CMD_W-1:0]  head_cmd;
   logic [DATA_W-1:0] head_op1, head_op2;

   seq_state_e        state_q, state_d;
   logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] cur_op2_q, cur_op2_d;
   logic [CMD_W-1:0]  req_cmd_q, req_cmd_d;
   logic [DATA_W-1:0] req_data_q, req_data_d;
   logic              cpl_valid_q, cpl_valid_d;
   logic [1:0]        cpl_resp_q, cpl_resp_d;
   logic [DATA_W-1:0] cpl_data_q, cpl_data_d;
   logic              cpl_timeout_q, cpl_timeout_d;
   logic              err_q, err_d;
   logic              resp_seen, done, load;

   // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = txn_valid_i && !full;

   assign head     = mem_q[rd_ptr_q[AW-1:0]];
   assign head_cmd = head[ENT_W-1 -: CMD_W];
   assign head_op1 = head[2*DATA_W-1 -: DATA_W];
   assign head_op2 = head[DATA_W-1:0];

   assign wr_ptr_d = wr_ptr_q + PW'(push);
   assign rd_ptr_d = rd_ptr_q + PW'(pop);

   assign resp_seen = resp_present(out_resp_i);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {txn_cmd_i, txn_op1_i, txn_op2_i};
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      cur_op2_d     = cur_op2_q;
      req_cmd_d     = CMD_W'(CMD_NOP);
      req_data_d    = '0;
      cpl_valid_d   = 1'b0;
      cpl_resp_d    = cpl_resp_q;
      cpl_data_d    = cpl_data_q;
      cpl_timeout_d = cpl_timeout_q;
      err_d         = err_q;
      done          = 1'b0;
      load          = 1'b0;
      pop           = 1'b0;

      case (state_q)
         IDLE: begin
            if (resp_seen) err_d = 1'b1;
            if (!empty) load = 1'b1;
         end
         OP1: begin
            if (resp_seen) err_d = 1'b1;
            // A queued NOP only occupies the OP1 slot and leaves a gap.
            if (req_cmd_q == CMD_W'(CMD_NOP)) begin
               state_d = IDLE;
            end else begin
               state_d    = OP2;
               req_data_d = cur_op2_q;
            end
         end
         OP2: begin
            if (resp_seen) err_d = 1'b1;
            state_d    = WAIT;
            wait_cnt_d = '0;
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + CW'(1);
            if (resp_seen) begin
               cpl_valid_d   = 1'b1;
               cpl_resp_d    = out_resp_i;
               cpl_data_d    = out_data_i;
               cpl_timeout_d = 1'b0;
               done          = 1'b1;
            end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
               cpl_valid_d   = 1'b1;
               cpl_resp_d    = RESP_NONE;
               cpl_data_d    = '0;
               cpl_timeout_d = 1'b1;
               done          = 1'b1;
            end
            if (done) begin
               wait_cnt_d = '0;
               if (!empty) load = 1'b1;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Popping the head launches OP1 at the same edge, back-to-back.
      if (load) begin
         pop        = 1'b1;
         state_d    = OP1;
         req_cmd_d  = head_cmd;
         req_data_d = head_op1;
         cur_op2_d  = head_op2;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         cur_op2_q     <= '0;
         req_cmd_q     <= CMD_W'(CMD_NOP);
         req_data_q    <= '0;
         cpl_valid_q   <= 1'b0;
         cpl_resp_q    <= RESP_NONE;
         cpl_data_q    <= '0;
         cpl_timeout_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         cur_op2_q     <= cur_op2_d;
         req_cmd_q     <= req_cmd_d;
         req_data_q    <= req_data_d;
         cpl_valid_q   <= cpl_valid_d;
         cpl_resp_q    <= cpl_resp_d;
         cpl_data_q    <= cpl_data_d;
         cpl_timeout_q <= cpl_timeout_d;
         err_q         <= err_d;
      end
   end

   assign txn_ready_o    = !full;
   assign req_cmd_o      = req_cmd_q;
   assign req_data_o     = req_data_q;
   assign cpl_valid_o    = cpl_valid_q;
   assign cpl_resp_o     = cpl_resp_q;
   assign cpl_data_o     = cpl_data_q;
   assign cpl_timeout_o  = cpl_timeout_q;
   assign busy_o         = (state_q != IDLE) || !empty;
   assign err_spurious_o = err_q;
   assign state_o        = state_q;

endmodule

// File: rtl/calc_req_sequencer.sv
// Multi-port calc request sequencer: NUM_PORTS fully independent channels,
// each a calc_port_seq on its own slice of the flattened buses.
module calc_req_sequencer
   import calc_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = 32,
   parameter int CMD_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                        c_clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        txn_valid,
   output logic [NUM_PORTS-1:0]        txn_ready,
   input  logic [NUM_PORTS*CMD_W-1:0]  txn_cmd,
   input  logic [NUM_PORTS*DATA_W-1:0] txn_op1,
   input  logic [NUM_PORTS*DATA_W-1:0] txn_op2,
   output logic [NUM_PORTS*CMD_W-1:0]  req_cmd_out,
   output logic [NUM_PORTS*DATA_W-1:0] req_data_out,
   input  logic [NUM_PORTS*2-1:0]      out_resp,
   input  logic [NUM_PORTS*DATA_W-1:0] out_data,
   output logic [NUM_PORTS-1:0]        cpl_valid,
   output logic [NUM_PORTS*2-1:0]      cpl_resp,
   output logic [NUM_PORTS*DATA_W-1:0] cpl_data,
   output logic [NUM_PORTS-1:0]        cpl_timeout,
   output logic [NUM_PORTS-1:0]        busy,
   output logic [NUM_PORTS-1:0]        err_spurious,
   output logic [NUM_PORTS*2-1:0]      dbg_state
);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      calc_port_seq #(
         .DATA_W     (DATA_W),
         .CMD_W      (CMD_W),
         .FIFO_DEPTH (FIFO_DEPTH),
         .TIMEOUT    (TIMEOUT)
      ) u_seq (
         .clk_i          (c_clk),
         .rst_ni         (reset),
         .txn_valid_i    (txn_valid[p]),
         .txn_ready_o    (txn_ready[p]),
         .txn_cmd_i      (txn_cmd[p*CMD_W +: CMD_W]),
         .txn_op1_i      (txn_op1[p*DATA_W +: DATA_W]),
         .txn_op2_i      (txn_op2[p*DATA_W +: DATA_W]),
         .req_cmd_o      (req_cmd_out[p*CMD_W +: CMD_W]),
         .req_data_o     (req_data_out[p*DATA_W +: DATA_W]),
         .out_resp_i     (out_resp[p*2 +: 2]),
         .out_data_i     (out_data[p*DATA_W +: DATA_W]),
         .cpl_valid_o    (cpl_valid[p]),
         .cpl_resp_o     (cpl_resp[p*2 +: 2]),
         .cpl_data_o     (cpl_data[p*DATA_W +: DATA_W]),
         .cpl_timeout_o  (cpl_timeout[p]),
         .busy_o         (busy[p]),
         .err_spurious_o (err_spurious[p]),
         .state_o        (dbg_state[p*2 +: 2])
      );
   end

endmodule

// File: tb/tb_calc_req_sequencer.sv
// Directed bench for calc_req_sequencer: completions go through an expected
// queue checked by a monitor; request timing and status flags checked inline.
module tb_calc_req_sequencer;
   localparam int NP = 4;
   localparam int DW = 32;
   localparam int CW = 4;

   logic c_clk = 1'b0;
   logic reset = 1'b0;
   logic [NP-1:0]    txn_valid, txn_ready, cpl_valid, cpl_timeout, busy, err_spurious;
   logic [NP*CW-1:0] txn_cmd, req_cmd_out;
   logic [NP*DW-1:0] txn_op1, txn_op2, req_data_out, out_data, cpl_data;
   logic [NP*2-1:0]  out_resp, cpl_resp, dbg_state;

   int checks = 0;
   int errors = 0;
   // entry = {port[1:0], timeout, resp[1:0], data[31:0]}
   logic [36:0] exp_q[$];

   calc_req_sequencer #(
      .NUM_PORTS(NP), .DATA_W(DW), .CMD_W(CW), .FIFO_DEPTH(4), .TIMEOUT(16)
   ) dut (
      .c_clk(c_clk), .reset(reset),
      .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_cmd(txn_cmd),
      .txn_op1(txn_op1), .txn_op2(txn_op2),
      .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
      .out_resp(out_resp), .out_data(out_data),
      .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_data(cpl_data),
      .cpl_timeout(cpl_timeout), .busy(busy), .err_spurious(err_spurious),
      .dbg_state(dbg_state)
   );

   always #5 c_clk = ~c_clk;

   task automatic tick();
      @(negedge c_clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic set_txn(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2);
      txn_valid[p]        = 1'b1;
      txn_cmd[p*CW +: CW] = cmd;
      txn_op1[p*DW +: DW] = op1;
      txn_op2[p*DW +: DW] = op2;
   endtask

   task automatic push_txn(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                           input logic [31:0] op2);
      bit accepted = 1'b0;
      set_txn(p, cmd, op1, op2);
      for (int n = 0; n < 200 && !accepted; n++) begin
         if (txn_ready[p]) accepted = 1'b1;
         tick();
      end
      txn_valid[p] = 1'b0;
      if (!accepted) check($sformatf("push_accept_p%0d", p), 32'(accepted), 32'd1);
   endtask

   task automatic set_resp(input int p, input logic [1:0] r, input logic [31:0] d);
      out_resp[p*2 +: 2]   = r;
      out_data[p*DW +: DW] = d;
   endtask

   task automatic expect_cpl(input int p, input logic [1:0] r, input logic to,
                             input logic [31:0] d);
      exp_q.push_back({2'(p), to, r, d});
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy != '0 && n < 400) begin
         tick();
         n++;
      end
      check("idle_within_bound", 32'(busy), 32'd0);
      tick();
   endtask

   always @(negedge c_clk) begin : monitor
      int idx;
      logic [36:0] got;
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            if (cpl_valid[p]) begin
               idx = -1;
               for (int i = 0; i < exp_q.size(); i++)
                  if (idx < 0 && exp_q[i][36:35] == 2'(p)) idx = i;
               got = {2'(p), cpl_timeout[p], cpl_resp[p*2 +: 2], cpl_data[p*DW +: DW]};
               checks++;
               if (idx < 0) begin
                  errors++;
                  $display("FAIL cpl_unexpected_p%0d actual=%h required=no completion", p, got);
               end else begin
                  if (got !== exp_q[idx]) begin
                     errors++;
                     $display("FAIL cpl_record_p%0d actual=%h required=%h", p, got, exp_q[idx]);
                  end
                  exp_q.delete(idx);
               end
            end
         end
      end
   end

   initial begin
      txn_valid = '0; txn_cmd = '0; txn_op1 = '0; txn_op2 = '0;
      out_resp  = '0; out_data = '0;
      repeat (3) tick();
      reset = 1'b1;
      tick();

      for (int p = 0; p < NP; p++) begin
         check($sformatf("rst_req_cmd_p%0d", p), 32'(req_cmd_out[p*CW +: CW]), 32'd0);
         check($sformatf("rst_req_data_p%0d", p), req_data_out[p*DW +: DW], 32'd0);
         check($sformatf("rst_cpl_p%0d", p),
               {cpl_data[p*DW +: 28], cpl_resp[p*2 +: 2], cpl_valid[p], cpl_timeout[p]}, 32'd0);
         check($sformatf("rst_flags_p%0d", p),
               {29'd0, busy[p], err_spurious[p], txn_ready[p]}, 32'd1);
      end

      // Port 1: ADD with an OK response two cycles into WAIT.
      push_txn(0, 4'd1, 32'hFFFF0000, 32'h0000FFFF);
      check("t1_busy", 32'(busy[0]), 32'd1);
      tick();
      check("t1_op1_cmd", 32'(req_cmd_out[3:0]), 32'd1);
      check("t1_op1_data", req_data_out[31:0], 32'hFFFF0000);
      tick();
      check("t1_op2_cmd", 32'(req_cmd_out[3:0]), 32'd0);
      check("t1_op2_data", req_data_out[31:0], 32'h0000FFFF);
      tick();
      check("t1_wait_data", req_data_out[31:0], 32'd0);
      check("t1_wait_state", 32'(dbg_state[1:0]), 32'd3);
      tick();
      set_resp(0, 2'd1, 32'hFFFFFFFF);
      expect_cpl(0, 2'd1, 1'b0, 32'hFFFFFFFF);
      tick();
      out_resp = '0;
      check("t1_cpl_pulse", 32'(cpl_valid[0]), 32'd1);
      tick();
      check("t1_cpl_one_cycle", 32'(cpl_valid[0]), 32'd0);
      check("t1_cpl_data_held", cpl_data[31:0], 32'hFFFFFFFF);
      check("t1_idle", 32'(busy[0]), 32'd0);
      wait_idle();

      // Port 3: SUB with no response -> timeout, then a late response is spurious.
      expect_cpl(2, 2'd0, 1'b1, 32'd0);
      push_txn(2, 4'd2, 32'h80000000, 32'h1);
      repeat (18) tick();
      check("t2_no_cpl_early", 32'(cpl_valid[2]), 32'd0);
      tick();
      check("t2_timeout_pulse", 32'(cpl_valid[2]), 32'd1);
      check("t2_timeout_flag", 32'(cpl_timeout[2]), 32'd1);
      check("t2_err_before", 32'(err_spurious[2]), 32'd0);
      set_resp(2, 2'd1, 32'h1234);
      tick();
      out_resp = '0;
      check("t2_err_spurious", 32'(err_spurious[2]), 32'd1);
      wait_idle();

      // Port 2: never answered; FIFO fills after 5 accepted pushes.
      for (int i = 0; i < 6; i++) expect_cpl(1, 2'd0, 1'b1, 32'd0);
      for (int i = 0; i < 5; i++) push_txn(1, 4'd1, 32'(i), 32'(i + 1));
      check("t3_ready_low", 32'(txn_ready[1]), 32'd0);
      repeat (14) tick();
      check("t3_ready_still_low", 32'(txn_ready[1]), 32'd0);
      check("t3_no_cpl_yet", 32'(cpl_valid[1]), 32'd0);
      tick();
      check("t3_first_timeout", 32'(cpl_valid[1]), 32'd1);
      check("t3_ready_back", 32'(txn_ready[1]), 32'd1);
      push_txn(1, 4'd1, 32'h10, 32'h20);
      wait_idle();

      // All ports LSH in the same cycle, staggered responses.
      for (int p = 0; p < NP; p++) set_txn(p, 4'd5, 32'h0F0F0F0F, 32'd4);
      tick();
      txn_valid = '0;
      tick();
      for (int p = 0; p < NP; p++) begin
         check($sformatf("t4_op1_cmd_p%0d", p), 32'(req_cmd_out[p*CW +: CW]), 32'd5);
         check($sformatf("t4_op1_data_p%0d", p), req_data_out[p*DW +: DW], 32'h0F0F0F0F);
      end
      tick();
      for (int p = 0; p < NP; p++)
         check($sformatf("t4_op2_data_p%0d", p), req_data_out[p*DW +: DW], 32'd4);
      tick();
      for (int k = 0; k < NP; k++) begin
         set_resp(k, 2'd1, 32'hF0F0F0F0);
         expect_cpl(k, 2'd1, 1'b0, 32'hF0F0F0F0);
         tick();
         out_resp = '0;
      end
      wait_idle();

      // Port 1: ADD, queued NOP gap, ADD -> exactly two completions.
      push_txn(0, 4'd1, 32'd1, 32'd2);
      push_txn(0, 4'd0, 32'h55, 32'h66);
      push_txn(0, 4'd1, 32'd3, 32'd4);
      tick();
      set_resp(0, 2'd1, 32'd3);
      expect_cpl(0, 2'd1, 1'b0, 32'd3);
      tick();
      out_resp = '0;
      check("t6_nop_cmd", 32'(req_cmd_out[3:0]), 32'd0);
      check("t6_nop_data", req_data_out[31:0], 32'h55);
      tick();
      check("t6_gap_state", 32'(dbg_state[1:0]), 32'd0);
      check("t6_gap_data", req_data_out[31:0], 32'd0);
      tick();
      check("t6_second_op1_cmd", 32'(req_cmd_out[3:0]), 32'd1);
      check("t6_second_op1_data", req_data_out[31:0], 32'd3);
      tick();
      check("t6_second_op2_data", req_data_out[31:0], 32'd4);
      tick();
      set_resp(0, 2'd2, 32'd7);
      expect_cpl(0, 2'd2, 1'b0, 32'd7);
      tick();
      out_resp = '0;
      wait_idle();

      // Port 4: reset during WAIT with two entries queued.
      push_txn(3, 4'd1, 32'd1, 32'd1);
      push_txn(3, 4'd1, 32'd2, 32'd2);
      push_txn(3, 4'd1, 32'd3, 32'd3);
      repeat (2) tick();
      check("t5_in_wait", 32'(dbg_state[7:6]), 32'd3);
      check("t5_busy_before", 32'(busy[3]), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t5_rst_req_cmd", 32'(req_cmd_out[15:12]), 32'd0);
      check("t5_rst_busy", 32'(busy[3]), 32'd0);
      check("t5_rst_cpl", 32'(cpl_valid), 32'd0);
      @(posedge c_clk);
      @(posedge c_clk);
      @(negedge c_clk);
      reset = 1'b1;
      repeat (4) tick();
      check("t5_busy_after", 32'(busy), 32'd0);
      check("t5_ready_after", 32'(txn_ready), 32'hF);
      check("t5_err_cleared", 32'(err_spurious), 32'd0);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
